jet_readout_ctrl: RTL and testbench
===================================

Name: jet_readout_ctrl

Overview:
- Downstream consumer of the found-jet store.
- On an end-of-event strobe, reads every jet the store holds for the event through the store's registered read port (addr -> data latency RD_LAT).
- Emits a framed stream to the output link: one header word, then the jets in address order, with valid/ready backpressure and a last flag.
- Truncates events with more than MAX_JETS jets and flags the truncation.

Parameters:
- DATA_W, 32, width of jet word and output word.
- ADDR_W, 8, store address / count width.
- RD_LAT, 2, store read latency in clk cycles, addr presented to data valid.
- MAX_JETS, 16, maximum jets forwarded per event (1..2^ADDR_W-1).
- HDR_TAG, 8'hA5, tag placed in header bits [31:24].

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- eoe  in  1  end-of-event pulse; jet_count is stable and final in this cycle.
- jet_count  in  ADDR_W  number of jets written to the store this event.
- rd_addr  out  ADDR_W  store read address.
- rd_data  in  DATA_W  store read data, valid RD_LAT cycles after rd_addr.
- out_data  out  DATA_W  output word.
- out_valid  out  1  out_data valid.
- out_last  out  1  final word of event, qualified by out_valid.
- out_ready  in  1  downstream accept.
- busy  out  1  high from the cycle after an accepted eoe until the last word is accepted.
- trunc  out  1  one-cycle pulse when jet_count > MAX_JETS at eoe.
- eoe_drop  out  1  one-cycle pulse when eoe arrives while busy.

Behaviour:
- Reset values: rd_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, trunc=0, eoe_drop=0, event counter=0, FIFO empty. State returns to IDLE.
- Reset mid-event abandons the frame. In-flight store reads are discarded: a reset-cycle counter masks capture for RD_LAT cycles.
- States:
  - IDLE: on eoe, latch n = min(jet_count, MAX_JETS); trunc pulses the next cycle if jet_count > MAX_JETS. Go to HDR.
  - HDR: out_valid=1, out_data={HDR_TAG, evt_cnt[15:0], n[7:0]}, out_last=(n==0). When out_ready is high: increment evt_cnt (wraps 0xFFFF->0); go to IDLE if n==0, else DRAIN.
  - READ (concurrent with HDR/DRAIN): issue addresses 0..n-1, one per cycle, only while credit is available. rd_addr returns to 0 once n addresses have been issued.
  - DRAIN: the output presents the FIFO head. out_last=1 on the n-th jet. When the last word is accepted, go to IDLE; busy drops the same edge.
- Issue starts at T+1 for eoe at cycle T, in parallel with the header.
- Returned data is captured into a first-word-fallthrough skid FIFO of depth RD_LAT+2.
- Credit rule: issued_in_flight + fifo_count < RD_LAT+2. The FIFO never overflows regardless of out_ready.
- Header always precedes jets. FIFO data is not shown until the header is accepted.
- out_data/out_valid/out_last hold stable while out_valid && !out_ready.
- With out_ready held high:
  - header at T+1;
  - first jet at T+RD_LAT+2;
  - jets on consecutive cycles thereafter;
  - frame length = n+1 words.
- eoe while busy: ignored, eoe_drop pulses next cycle, frame unaffected. eoe in the same cycle the last word is accepted is also dropped.
- jet_count = 0: header-only frame, out_last=1 on header, no reads issued.
- jet_count > MAX_JETS: only addresses 0..MAX_JETS-1 are read. Header count field = MAX_JETS.

Test Plan:
- reset; eoe with jet_count=3, store[0..2]=0x11,0x22,0x33, out_ready=1 -> header 0xA5000003 at T+1; 0x11,0x22,0x33 at T+4..T+6; out_last only on 0x33; busy low at T+7.
- eoe with jet_count=0 (second event) -> single word 0xA5000100, out_valid and out_last both high; rd_addr stays 0.
- jet_count=20, MAX_JETS=16 -> trunc pulse at T+1; header count 0x10; 16 jets from addr 0..15; addr 16 never driven.
- jet_count=8, out_ready toggled 1,0,0,1 repeating -> all 8 jets delivered in order, no duplicates or losses; out_data stable while stalled; FIFO occupancy never exceeds RD_LAT+2.
- second eoe 3 cycles after first (count 5) -> eoe_drop pulse; only one frame of 6 words; evt_cnt increments once.
- reset asserted during DRAIN of a 10-jet event, then eoe count=2 -> no stale words emitted; fresh frame with header evt_cnt=0.

Source files
------------

// File: rtl/jet_readout_ctrl.sv
// Reads the found-jet store at end of event and emits a framed stream: one header
// word followed by up to MAX_JETS jets, with valid/ready backpressure and a last flag.
module jet_readout_ctrl #(
    parameter int           DATA_W   = 32,
    parameter int           ADDR_W   = 8,
    parameter int           RD_LAT   = 2,
    parameter int           MAX_JETS = 16,
    parameter logic [7:0]   HDR_TAG  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              eoe,
    input  logic [ADDR_W-1:0] jet_count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              trunc,
    output logic              eoe_drop
);
    // Output handshake: a word transfers on a clk edge where out_valid && out_ready;
    // while out_valid && !out_ready, out_data/out_valid/out_last hold unchanged.

    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int MW    = $clog2(RD_LAT + 1);
    localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(MAX_JETS);

    typedef enum logic [1:0] {IDLE, HDR, DRAIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] n_q, iss_cnt, out_cnt;
    logic [15:0]       evt_cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic [MW-1:0]     mask_cnt;
    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     fifo_count, in_flight;
    logic              issue, capture, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + CW'(vld_pipe[i]);
    end

    // Credit counts reads still in the store pipeline so the FIFO can never overflow.
    assign issue   = (state != IDLE) && (iss_cnt != n_q) &&
                     ((int'(in_flight) + int'(fifo_count)) < DEPTH);
    assign rd_addr = issue ? iss_cnt : '0;
    assign capture = vld_pipe[RD_LAT-1] && (mask_cnt == '0);
    assign pop     = (state == DRAIN) && (fifo_count != '0) && out_ready;
    assign busy    = (state != IDLE);

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            IDLE: if (eoe) state_nxt = HDR;
            HDR: begin
                out_valid = 1'b1;
                out_data  = DATA_W'({HDR_TAG, evt_cnt, n_q[7:0]});
                out_last  = (n_q == '0);
                if (out_ready) state_nxt = (n_q == '0) ? IDLE : DRAIN;
            end
            DRAIN: begin
                out_valid = (fifo_count != '0);
                out_data  = fifo_mem[rd_ptr];
                out_last  = (out_cnt == n_q - 1'b1);
                if (pop && out_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            n_q        <= '0;
            iss_cnt    <= '0;
            out_cnt    <= '0;
            evt_cnt    <= '0;
            vld_pipe   <= '0;
            mask_cnt   <= MW'(RD_LAT);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            trunc      <= 1'b0;
            eoe_drop   <= 1'b0;
        end else begin
            state    <= state_nxt;
            trunc    <= (state == IDLE) && eoe && (jet_count > MAX_N);
            eoe_drop <= (state != IDLE) && eoe;
            if ((state == IDLE) && eoe) begin
                n_q     <= (jet_count > MAX_N) ? MAX_N : jet_count;
                iss_cnt <= '0;
                out_cnt <= '0;
            end else begin
                if (issue) iss_cnt <= iss_cnt + 1'b1;
                if (pop)   out_cnt <= out_cnt + 1'b1;
            end
            if ((state == HDR) && out_ready) evt_cnt <= evt_cnt + 16'd1;
            // Reads issued before a reset are still returning; keep them out of the FIFO.
            if (mask_cnt != '0) mask_cnt <= mask_cnt - 1'b1;
            vld_pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            if (capture && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (!capture && pop) fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) fifo_mem[wr_ptr] <= rd_data;
    end

endmodule

// File: tb/tb_jet_readout_ctrl.sv
// Directed bench for jet_readout_ctrl: behavioural store model, expected-word queue
// filled by the drivers, and a monitor that checks every accepted output word.
module tb_jet_readout_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int RD_LAT = 2;
    localparam int MAX_JETS = 16;
    localparam int DEPTH = RD_LAT + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              eoe = 1'b0;
    logic [ADDR_W-1:0] jet_count = '0;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid, out_last, out_ready;
    logic              busy, trunc, eoe_drop;

    jet_readout_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
                       .MAX_JETS(MAX_JETS), .HDR_TAG(8'hA5)) dut (
        .clk(clk), .reset(reset), .eoe(eoe), .jet_count(jet_count),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .trunc(trunc), .eoe_drop(eoe_drop)
    );

    // clock / reset
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // store model with RD_LAT registered read latency
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    initial for (int i = 0; i < 256; i++) mem[i] = 32'h11 * (i + 1);
    always @(posedge clk) begin
        rd_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data = rd_pipe[RD_LAT-1];

    // ready generator: steady level or the 1,0,0,1 stall pattern
    logic       ready_hold = 1'b1;
    logic       toggle_en = 1'b0;
    logic [3:0] pat = 4'b1001;
    int         ph = 0;
    always @(posedge clk) begin
        #1;
        if (toggle_en) begin
            out_ready = pat[ph];
            ph = (ph + 1) % 4;
        end else begin
            out_ready = ready_hold;
            ph = 0;
        end
    end

    // scoreboard
    int n_checks = 0;
    int n_fail = 0;
    logic [DATA_W:0] exp_q[$];
    logic [15:0]     exp_evt = 16'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compares every accepted word, and stall stability
    logic            stall_prev = 1'b0;
    logic [DATA_W:0] held;
    logic [DATA_W:0] e;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", {31'b0, out_valid, out_last, out_data}, {31'b0, 1'b1, held});
            if (busy)
                check("fifo_occ", 64'(dut.fifo_count <= DEPTH), 64'd1);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h last %0b expected none", out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {31'b0, out_last, out_data}, {31'b0, e});
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_last, out_data};
        end
    end

    // highest read address driven since last clear
    logic       max_clr = 1'b0;
    logic [7:0] max_addr = 8'd0;
    always @(negedge clk) begin
        if (max_clr) max_addr = 8'd0;
        else if (rd_addr > max_addr) max_addr = rd_addr;
    end

    // driver tasks
    task automatic push_frame(input int cnt);
        int n;
        n = (cnt > MAX_JETS) ? MAX_JETS : cnt;
        exp_q.push_back({(n == 0), 8'hA5, exp_evt, 8'(n)});
        for (int j = 0; j < n; j++) exp_q.push_back({(j == n - 1), mem[j]});
        exp_evt++;
    endtask

    task automatic pulse_eoe(input int cnt);
        @(posedge clk); #1;
        jet_count = 8'(cnt);
        eoe = 1'b1;
        @(posedge clk); #1;
        eoe = 1'b0;
    endtask

    task automatic clear_max();
        @(posedge clk); #1 max_clr = 1'b1;
        @(posedge clk); #1 max_clr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, 64'(busy), 64'd0);
        check({name, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        @(negedge clk);
        check("reset_state", {rd_addr, out_data, out_valid, out_last, busy, trunc, eoe_drop},
              {8'd0, 32'd0, 5'b00000});
        @(posedge clk); #1 reset = 1'b0;

        // event 1: three jets, ready high, cycle-exact timing
        push_frame(3);
        pulse_eoe(3);
        @(negedge clk);
        check("e1_hdr", {out_valid, out_last, busy, out_data}, {3'b101, 32'hA5000003});
        @(negedge clk);
        check("e1_gap_t2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("e1_gap_t3", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("e1_jet0", {out_valid, out_last, out_data}, {2'b10, 32'h11});
        @(negedge clk);
        @(negedge clk);
        check("e1_jet2", {out_valid, out_last, out_data}, {2'b11, 32'h33});
        @(negedge clk);
        check("e1_busy_low", 64'(busy), 64'd0);
        check("e1_queue", 64'(exp_q.size()), 64'd0);

        // event 2: zero jets, header-only frame
        clear_max();
        push_frame(0);
        pulse_eoe(0);
        @(negedge clk);
        check("e2_hdr", {out_valid, out_last, rd_addr, out_data}, {2'b11, 8'd0, 32'hA5000100});
        wait_idle("e2_idle");
        check("e2_no_reads", 64'(max_addr), 64'd0);

        // event 3: truncation 20 -> 16
        clear_max();
        push_frame(20);
        pulse_eoe(20);
        @(negedge clk);
        check("e3_trunc", {trunc, out_data}, {1'b1, 32'hA5000210});
        @(negedge clk);
        check("e3_trunc_pulse", 64'(trunc), 64'd0);
        wait_idle("e3_idle");
        check("e3_max_addr", 64'(max_addr), 64'd15);

        // event 4: eight jets under 1,0,0,1 ready pattern
        toggle_en = 1'b1;
        push_frame(8);
        pulse_eoe(8);
        wait_idle("e4_idle");
        @(posedge clk); #1 toggle_en = 1'b0;
        repeat (2) @(posedge clk);

        // event 5: second eoe three cycles after the first is dropped
        push_frame(5);
        pulse_eoe(5);
        @(posedge clk);
        pulse_eoe(7);
        @(negedge clk);
        check("e5_eoe_drop", {eoe_drop, trunc}, {1'b1, 1'b0});
        @(negedge clk);
        check("e5_drop_pulse", 64'(eoe_drop), 64'd0);
        wait_idle("e5_idle");

        // event 6: reset during drain abandons the frame
        push_frame(10);
        pulse_eoe(10);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        exp_evt = 16'd0;
        @(negedge clk);
        check("e6_after_reset", {out_valid, busy}, 64'd0);
        repeat (6) @(posedge clk);

        // event 7: fresh frame after reset
        push_frame(2);
        pulse_eoe(2);
        @(negedge clk);
        check("e7_hdr", {out_valid, out_data}, {1'b1, 32'hA5000002});
        wait_idle("e7_idle");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
